// File: rtl/execute_pipe.sv
// Y86-64 execute stage: ALU, condition codes, branch/cmov condition and the M pipeline register.
// Optional macro EXEC_EXC_CC_GATE_EN blocks CC updates while an older instruction carries an exception.
module execute_pipe (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  E_icode,
  input  logic [3:0]  E_ifun,
  input  logic [63:0] E_valA,
  input  logic [63:0] E_valB,
  input  logic [63:0] E_valC,
  input  logic [3:0]  E_dstE,
  input  logic [3:0]  E_dstM,
  input  logic [3:0]  E_stat,
  input  logic [3:0]  m_stat,
  input  logic [3:0]  W_stat,
  input  logic        M_bubble,
  output logic [3:0]  M_icode,
  output logic [3:0]  M_dstE,
  output logic [3:0]  M_dstM,
  output logic [63:0] M_valE,
  output logic [63:0] M_valA,
  output logic [3:0]  M_stat,
  output logic        M_cnd,
  output logic [63:0] e_valE,
  output logic [3:0]  e_dstE,
  output logic        e_cnd,
  output logic [2:0]  cc
);

  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_CMOV   = 4'h2;
  localparam logic [3:0] I_IRMOV  = 4'h3;
  localparam logic [3:0] I_RMMOV  = 4'h4;
  localparam logic [3:0] I_MRMOV  = 4'h5;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSH   = 4'hA;
  localparam logic [3:0] I_POP    = 4'hB;
  localparam logic [3:0] REG_NONE = 4'hF;
  localparam logic [3:0] S_AOK    = 4'h1;

  logic [63:0] alu_a;
  logic [63:0] alu_b;
  logic [63:0] alu_r;
  logic        alu_of;
  logic        cond;
  logic        cc_gate;
  logic        cc_load;

  always_comb begin
    alu_a = '0;
    case (E_icode)
      I_CMOV, I_OPQ:           alu_a = E_valA;
      I_IRMOV, I_RMMOV, I_MRMOV: alu_a = E_valC;
      I_CALL, I_PUSH:          alu_a = -64'sd8;
      I_RET, I_POP:            alu_a = 64'd8;
      default:                 alu_a = '0;
    endcase
  end

  always_comb begin
    alu_b = '0;
    case (E_icode)
      I_RMMOV, I_MRMOV, I_OPQ, I_CALL, I_RET, I_PUSH, I_POP: alu_b = E_valB;
      default: alu_b = '0;
    endcase
  end

  // Non-OPq icodes always add; OPq decodes ifun, unknown ifun yields zero.
  always_comb begin
    alu_r  = alu_b + alu_a;
    alu_of = (alu_a[63] == alu_b[63]) && (alu_r[63] != alu_a[63]);
    if (E_icode == I_OPQ) begin
      case (E_ifun)
        4'h0: begin
          alu_r  = alu_b + alu_a;
          alu_of = (alu_a[63] == alu_b[63]) && (alu_r[63] != alu_a[63]);
        end
        4'h1: begin
          alu_r  = alu_b - alu_a;
          alu_of = (alu_a[63] != alu_b[63]) && (alu_r[63] != alu_b[63]);
        end
        4'h2: begin
          alu_r  = alu_b & alu_a;
          alu_of = 1'b0;
        end
        4'h3: begin
          alu_r  = alu_b ^ alu_a;
          alu_of = 1'b0;
        end
        default: begin
          alu_r  = '0;
          alu_of = 1'b0;
        end
      endcase
    end
  end

`ifdef EXEC_EXC_CC_GATE_EN
  function automatic logic is_exc(input logic [3:0] s);
    return (s == 4'h2) || (s == 4'h3) || (s == 4'h4);
  endfunction
  assign cc_gate = !is_exc(m_stat) && !is_exc(W_stat);
`else
  logic unused_stat;
  assign unused_stat = ^{m_stat, W_stat};
  assign cc_gate     = 1'b1;
`endif

  assign cc_load = (E_icode == I_OPQ) && cc_gate;

  // cc is {ZF,SF,OF}; the condition always sees the value from before this edge.
  always_comb begin
    cond = 1'b0;
    case (E_ifun)
      4'h0:    cond = 1'b1;
      4'h1:    cond = (cc[1] ^ cc[0]) | cc[2];
      4'h2:    cond = cc[1] ^ cc[0];
      4'h3:    cond = cc[2];
      4'h4:    cond = !cc[2];
      4'h5:    cond = !(cc[1] ^ cc[0]);
      4'h6:    cond = !(cc[1] ^ cc[0]) && !cc[2];
      default: cond = 1'b0;
    endcase
  end

  assign e_valE = alu_r;
  assign e_cnd  = ((E_icode == I_JXX) || (E_icode == I_CMOV)) && cond;
  assign e_dstE = ((E_icode == I_CMOV) && !e_cnd) ? REG_NONE : E_dstE;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cc <= 3'b100;
    end else if (cc_load) begin
      cc <= {alu_r == 64'd0, alu_r[63], alu_of};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      M_icode <= I_NOP;
      M_dstE  <= REG_NONE;
      M_dstM  <= REG_NONE;
      M_valE  <= '0;
      M_valA  <= '0;
      M_stat  <= S_AOK;
      M_cnd   <= 1'b0;
    end else if (M_bubble) begin
      M_icode <= I_NOP;
      M_dstE  <= REG_NONE;
      M_dstM  <= REG_NONE;
      M_valE  <= '0;
      M_valA  <= '0;
      M_stat  <= S_AOK;
      M_cnd   <= 1'b0;
    end else begin
      M_icode <= E_icode;
      M_dstE  <= e_dstE;
      M_dstM  <= E_dstM;
      M_valE  <= e_valE;
      M_valA  <= E_valA;
      M_stat  <= E_stat;
      M_cnd   <= e_cnd;
    end
  end

endmodule

// File: tb/tb_execute_pipe.sv
// Randomized bench for execute_pipe against a behavioural model, plus directed literal cases.
// Expectations for exception gating follow EXEC_EXC_CC_GATE_EN when it is defined.
module tb_execute_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  E_icode, E_ifun, E_dstE, E_dstM, E_stat, m_stat, W_stat;
  logic [63:0] E_valA, E_valB, E_valC;
  logic        M_bubble;
  logic [3:0]  M_icode, M_dstE, M_dstM, M_stat;
  logic [63:0] M_valE, M_valA, e_valE;
  logic [3:0]  e_dstE;
  logic        M_cnd, e_cnd;
  logic [2:0]  cc;

  int errors = 0;
  int checks = 0;
  int txn = 0;

  // model state
  logic [2:0]  m_cc;
  logic [3:0]  m_icode, m_dstE, m_dstM, m_mstat;
  logic [63:0] m_valE, m_valA;
  logic        m_cnd;
  // model combinational expectations for the current E inputs
  logic [63:0] x_valE;
  logic [3:0]  x_dstE;
  logic        x_cnd, x_setcc;
  logic [2:0]  x_flags;

  always #5 clk = ~clk;

  execute_pipe dut (
    .clk(clk), .rst_n(rst_n),
    .E_icode(E_icode), .E_ifun(E_ifun),
    .E_valA(E_valA), .E_valB(E_valB), .E_valC(E_valC),
    .E_dstE(E_dstE), .E_dstM(E_dstM), .E_stat(E_stat),
    .m_stat(m_stat), .W_stat(W_stat), .M_bubble(M_bubble),
    .M_icode(M_icode), .M_dstE(M_dstE), .M_dstM(M_dstM),
    .M_valE(M_valE), .M_valA(M_valA), .M_stat(M_stat), .M_cnd(M_cnd),
    .e_valE(e_valE), .e_dstE(e_dstE), .e_cnd(e_cnd), .cc(cc)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic is_exc(input logic [3:0] s);
    return (s == 4'h2) || (s == 4'h3) || (s == 4'h4);
  endfunction

  task automatic model_reset();
    m_cc = 3'b100; m_icode = 4'h1; m_dstE = 4'hF; m_dstM = 4'hF;
    m_valE = '0; m_valA = '0; m_mstat = 4'h1; m_cnd = 1'b0;
  endtask

  task automatic model_eval();
    logic [63:0] a, b, r;
    logic [64:0] w;
    logic of, zf, sf, ov, c;
    if (E_icode == 4'h2 || E_icode == 4'h6) a = E_valA;
    else if (E_icode inside {4'h3, 4'h4, 4'h5}) a = E_valC;
    else if (E_icode == 4'h8 || E_icode == 4'hA) a = 64'hFFFF_FFFF_FFFF_FFF8;
    else if (E_icode == 4'h9 || E_icode == 4'hB) a = 64'd8;
    else a = 64'd0;
    b = (E_icode inside {4'h4, 4'h5, 4'h6, 4'h8, 4'h9, 4'hA, 4'hB}) ? E_valB : 64'd0;
    of = 1'b0;
    r = a + b;
    if (E_icode == 4'h6) begin
      // overflow: the exact 65-bit signed result does not fit in 64 bits
      if (E_ifun == 4'h0) begin
        w = {b[63], b} + {a[63], a}; r = w[63:0]; of = w[64] != w[63];
      end else if (E_ifun == 4'h1) begin
        w = {b[63], b} - {a[63], a}; r = w[63:0]; of = w[64] != w[63];
      end else if (E_ifun == 4'h2) r = b & a;
      else if (E_ifun == 4'h3) r = b ^ a;
      else r = 64'd0;
    end
    zf = m_cc[2]; sf = m_cc[1]; ov = m_cc[0];
    case (E_ifun)
      4'h0: c = 1'b1;
      4'h1: c = (sf != ov) || zf;
      4'h2: c = sf != ov;
      4'h3: c = zf;
      4'h4: c = !zf;
      4'h5: c = sf == ov;
      4'h6: c = (sf == ov) && !zf;
      default: c = 1'b0;
    endcase
    x_valE  = r;
    x_cnd   = (E_icode == 4'h7 || E_icode == 4'h2) ? c : 1'b0;
    x_dstE  = (E_icode == 4'h2 && !x_cnd) ? 4'hF : E_dstE;
    x_flags = {r == 64'd0, r[63], of};
`ifdef EXEC_EXC_CC_GATE_EN
    x_setcc = (E_icode == 4'h6) && !is_exc(m_stat) && !is_exc(W_stat);
`else
    x_setcc = (E_icode == 4'h6);
`endif
  endtask

  // One transaction: compare at the falling edge, advance the model at the rising edge.
  task automatic cycle();
    @(negedge clk);
    model_eval();
    check("e_valE", e_valE, x_valE);
    check("e_dstE", {60'd0, e_dstE}, {60'd0, x_dstE});
    check("e_cnd", {63'd0, e_cnd}, {63'd0, x_cnd});
    check("cc", {61'd0, cc}, {61'd0, m_cc});
    check("M_icode", {60'd0, M_icode}, {60'd0, m_icode});
    check("M_dstE", {60'd0, M_dstE}, {60'd0, m_dstE});
    check("M_dstM", {60'd0, M_dstM}, {60'd0, m_dstM});
    check("M_valE", M_valE, m_valE);
    check("M_valA", M_valA, m_valA);
    check("M_stat", {60'd0, M_stat}, {60'd0, m_mstat});
    check("M_cnd", {63'd0, M_cnd}, {63'd0, m_cnd});
    $display("txn %0d icode=%h ifun=%h valA=%h valB=%h bub=%b e_valE=%h e_cnd=%b cc=%b",
             txn, E_icode, E_ifun, E_valA, E_valB, M_bubble, e_valE, e_cnd, cc);
    txn++;
    @(posedge clk);
    if (x_setcc) m_cc = x_flags;
    if (M_bubble) begin
      m_icode = 4'h1; m_dstE = 4'hF; m_dstM = 4'hF;
      m_valE = '0; m_valA = '0; m_mstat = 4'h1; m_cnd = 1'b0;
    end else begin
      m_icode = E_icode; m_dstE = x_dstE; m_dstM = E_dstM;
      m_valE = x_valE; m_valA = E_valA; m_mstat = E_stat; m_cnd = x_cnd;
    end
    #1;
  endtask

  task automatic drive(input logic [3:0] ic, input logic [3:0] fn, input logic [63:0] a,
                       input logic [63:0] b, input logic [63:0] c, input logic [3:0] de);
    E_icode = ic; E_ifun = fn; E_valA = a; E_valB = b; E_valC = c;
    E_dstE = de; E_dstM = 4'hF; E_stat = 4'h1; M_bubble = 1'b0;
    m_stat = 4'h1; W_stat = 4'h1;
  endtask

  function automatic logic [63:0] rnd64();
    case ($urandom_range(0, 5))
      0: return 64'd0;
      1: return 64'h7FFF_FFFF_FFFF_FFFF;
      2: return 64'h8000_0000_0000_0000;
      3: return 64'(($urandom_range(0, 15)));
      default: return {$urandom, $urandom};
    endcase
  endfunction

  function automatic logic [3:0] rnd_stat();
    return ($urandom_range(0, 9) < 7) ? 4'h1 : 4'($urandom_range(0, 4));
  endfunction

  initial begin
    rst_n = 1'b0;
    drive(4'h1, 4'h0, 64'd0, 64'd0, 64'd0, 4'hF);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("reset_cc", {61'd0, cc}, 64'b100);
    check("reset_M_icode", {60'd0, M_icode}, 64'h1);
    #2 rst_n = 1'b1;
    cycle();

    // sub: 5 - 7 = -2, SF set
    drive(4'h6, 4'h1, 64'd7, 64'd5, 64'd0, 4'h2);
    #1 check("sub_e_valE", e_valE, 64'hFFFF_FFFF_FFFF_FFFE);
    cycle();
    check("sub_cc", {61'd0, cc}, 64'b010);
    check("sub_M_valE", M_valE, 64'hFFFF_FFFF_FFFF_FFFE);

    // asynchronous reset mid-cycle
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_cc", {61'd0, cc}, 64'b100);
    check("async_rst_M_icode", {60'd0, M_icode}, 64'h1);
    check("async_rst_M_dstE", {60'd0, M_dstE}, 64'hF);
    check("async_rst_M_stat", {60'd0, M_stat}, 64'h1);
    model_reset();
    rst_n = 1'b1;
    cycle();

    // signed overflow on add
    drive(4'h6, 4'h0, 64'h7FFF_FFFF_FFFF_FFFF, 64'h7FFF_FFFF_FFFF_FFFF, 64'd0, 4'h2);
    #1 check("add_e_valE", e_valE, 64'hFFFF_FFFF_FFFF_FFFE);
    cycle();
    check("add_cc", {61'd0, cc}, 64'b011);

    // cmovle with cc=000 is not taken
    drive(4'h6, 4'h0, 64'd1, 64'd1, 64'd0, 4'h2);
    cycle();
    drive(4'h2, 4'h1, 64'h55, 64'd0, 64'd0, 4'h3);
    #1;
    check("cmovle_nt_cnd", {63'd0, e_cnd}, 64'd0);
    check("cmovle_nt_dstE", {60'd0, e_dstE}, 64'hF);
    cycle();
    check("cmovle_nt_M_dstE", {60'd0, M_dstE}, 64'hF);

    // cmovle with cc=100 is taken
    drive(4'h6, 4'h3, 64'd5, 64'd5, 64'd0, 4'h2);
    cycle();
    drive(4'h2, 4'h1, 64'h55, 64'd0, 64'd0, 4'h3);
    #1 check("cmovle_t_dstE", {60'd0, e_dstE}, 64'h3);
    cycle();

    // stack pointer arithmetic leaves cc alone
    drive(4'hA, 4'h0, 64'd0, 64'h100, 64'd0, 4'h4);
    #1 check("push_e_valE", e_valE, 64'hF8);
    cycle();
    check("push_cc", {61'd0, cc}, 64'b100);
    drive(4'hB, 4'h0, 64'd0, 64'h100, 64'd0, 4'h4);
    #1 check("pop_e_valE", e_valE, 64'h108);
    cycle();
    check("pop_cc", {61'd0, cc}, 64'b100);

    // OPq behind an older exception
    drive(4'h6, 4'h0, 64'd1, 64'd1, 64'd0, 4'h2);
    m_stat = 4'h3;
    cycle();
`ifdef EXEC_EXC_CC_GATE_EN
    check("gate_cc", {61'd0, cc}, 64'b100);
`else
    check("gate_cc", {61'd0, cc}, 64'b000);
`endif

    // bubble with a taken jump in E
    drive(4'h7, 4'h0, 64'd0, 64'd0, 64'h1234, 4'hF);
    M_bubble = 1'b1;
    cycle();
    check("bubble_M_icode", {60'd0, M_icode}, 64'h1);
    check("bubble_M_cnd", {63'd0, M_cnd}, 64'd0);

    for (int i = 0; i < 400; i++) begin
      E_icode  = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(12, 15)) : 4'($urandom_range(0, 11));
      E_ifun   = (E_icode == 4'h6) ? 4'($urandom_range(0, 3)) : 4'($urandom_range(0, 8));
      E_valA   = rnd64();
      E_valB   = rnd64();
      E_valC   = rnd64();
      E_dstE   = 4'($urandom_range(0, 15));
      E_dstM   = 4'($urandom_range(0, 15));
      E_stat   = 4'($urandom_range(1, 4));
      m_stat   = rnd_stat();
      W_stat   = rnd_stat();
      M_bubble = ($urandom_range(0, 9) == 0);
      cycle();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
